// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the read requester's state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_RESP  = 3'd3,
        ST_FLUSH = 3'd4
    } rd_state_t;

endpackage

// File: rtl/axi_lite_read_requester_if.sv
// Command/response port plus AXI4-Lite AR/R channels of the read requester.
// The master modport is the requester's view; slave is the command source plus subordinate.
interface axi_lite_read_requester_if #(
    parameter int unsigned ADDRESS_SIZE = 32,
    parameter int unsigned DATA_SIZE    = 32
);
    logic [ADDRESS_SIZE-1:0] cmd_address;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [DATA_SIZE-1:0]    rsp_data;
    logic [1:0]              rsp_resp;
    logic                    rsp_timeout;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ADDRESS_SIZE-1:0] m_araddr;
    logic                    m_arvalid;
    logic                    m_arready;
    logic [DATA_SIZE-1:0]    m_rdata;
    logic [1:0]              m_rresp;
    logic                    m_rvalid;
    logic                    m_rready;

    modport master (
        input  cmd_address, cmd_valid, rsp_ready, m_arready, m_rdata, m_rresp, m_rvalid,
        output cmd_ready, rsp_data, rsp_resp, rsp_timeout, rsp_valid, m_araddr, m_arvalid, m_rready
    );

    modport slave (
        output cmd_address, cmd_valid, rsp_ready, m_arready, m_rdata, m_rresp, m_rvalid,
        input  cmd_ready, rsp_data, rsp_resp, rsp_timeout, rsp_valid, m_araddr, m_arvalid, m_rready
    );

endinterface

// File: rtl/axi_lite_watchdog.sv
// Saturating cycle counter; o_expired marks the LIMIT-th enabled cycle since the last clear.
module axi_lite_watchdog #(
    parameter int unsigned LIMIT = 256
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int unsigned    CW   = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CW-1:0]  LAST = CW'((LIMIT == 0) ? 0 : LIMIT - 1);
    localparam logic [CW-1:0]  SAT  = CW'(LIMIT);

    logic [CW-1:0] r_count;

    always_ff @(posedge aclk) begin
        if (!aresetn || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != SAT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // LIMIT of zero disables the watchdog entirely
    assign o_expired = (LIMIT != 0) && i_enable && (r_count == LAST);

endmodule

// File: rtl/axi_lite_read_requester.sv
// Single-outstanding AXI4-Lite read initiator with watchdog; a timed-out transaction is
// still completed on the bus (FLUSH) so AR/R handshake rules are never broken.
module axi_lite_read_requester
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE   = 32,
    parameter int unsigned DATA_SIZE      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    axi_lite_read_requester_if.master   bus,
    output logic                        busy
);
    rd_state_t               r_state, w_state;
    logic                    r_cmd_ready, w_cmd_ready;
    logic [ADDRESS_SIZE-1:0] r_araddr, w_araddr;
    logic                    r_arvalid, w_arvalid;
    logic                    r_rready, w_rready;
    logic [DATA_SIZE-1:0]    r_rsp_data, w_rsp_data;
    logic [1:0]              r_rsp_resp, w_rsp_resp;
    logic                    r_rsp_timeout, w_rsp_timeout;
    logic                    r_rsp_valid, w_rsp_valid;
    logic                    r_busy, w_busy;
    logic                    r_pending, w_pending;
    logic                    r_ar_done, w_ar_done;
    logic                    w_ar_hs, w_r_hs, w_wd_clear, w_wd_enable, w_expired;

    assign w_ar_hs     = r_arvalid && bus.m_arready;
    assign w_r_hs      = r_rready && bus.m_rvalid;
    assign w_wd_enable = (r_state == ST_ADDR) || (r_state == ST_DATA);

    axi_lite_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_enable),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state       = r_state;
        w_cmd_ready   = r_cmd_ready;
        w_araddr      = r_araddr;
        w_arvalid     = r_arvalid;
        w_rready      = r_rready;
        w_rsp_data    = r_rsp_data;
        w_rsp_resp    = r_rsp_resp;
        w_rsp_timeout = r_rsp_timeout;
        w_rsp_valid   = r_rsp_valid;
        w_pending     = r_pending;
        w_ar_done     = r_ar_done;
        w_wd_clear    = 1'b0;

        // AR completion is tracked independently of state so RESP/FLUSH can retire it
        if (w_ar_hs) begin
            w_arvalid = 1'b0;
            w_ar_done = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (r_cmd_ready && bus.cmd_valid) begin
                    w_araddr    = bus.cmd_address;
                    w_arvalid   = 1'b1;
                    w_cmd_ready = 1'b0;
                    w_ar_done   = 1'b0;
                    w_pending   = 1'b0;
                    w_wd_clear  = 1'b1;
                    w_state     = ST_ADDR;
                end else begin
                    w_cmd_ready = 1'b1;
                end
            end
            ST_ADDR, ST_DATA: begin
                if (w_r_hs) begin
                    w_rready      = 1'b0;
                    w_rsp_data    = bus.m_rdata;
                    w_rsp_resp    = bus.m_rresp;
                    w_rsp_timeout = 1'b0;
                    w_rsp_valid   = 1'b1;
                    w_state       = ST_RESP;
                end else if (w_expired) begin
                    w_rready      = 1'b0;
                    w_rsp_data    = '0;
                    w_rsp_resp    = RESP_DECERR;
                    w_rsp_timeout = 1'b1;
                    w_rsp_valid   = 1'b1;
                    w_pending     = 1'b1;
                    w_state       = ST_RESP;
                end else if ((r_state == ST_ADDR) && w_ar_hs) begin
                    w_rready = 1'b1;
                    w_state  = ST_DATA;
                end
            end
            ST_RESP: begin
                if (r_rsp_valid && bus.rsp_ready) begin
                    w_rsp_valid = 1'b0;
                    if (r_pending) begin
                        w_state = ST_FLUSH;
                    end else begin
                        w_cmd_ready = 1'b1;
                        w_state     = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                if (w_r_hs) begin
                    w_rready    = 1'b0;
                    w_pending   = 1'b0;
                    w_cmd_ready = 1'b1;
                    w_state     = ST_IDLE;
                end else if (r_ar_done) begin
                    w_rready = 1'b1;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        w_busy = (w_state != ST_IDLE);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state       <= ST_IDLE;
            r_cmd_ready   <= 1'b0;
            r_araddr      <= '0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_resp    <= '0;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_pending     <= 1'b0;
            r_ar_done     <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_cmd_ready   <= w_cmd_ready;
            r_araddr      <= w_araddr;
            r_arvalid     <= w_arvalid;
            r_rready      <= w_rready;
            r_rsp_data    <= w_rsp_data;
            r_rsp_resp    <= w_rsp_resp;
            r_rsp_timeout <= w_rsp_timeout;
            r_rsp_valid   <= w_rsp_valid;
            r_busy        <= w_busy;
            r_pending     <= w_pending;
            r_ar_done     <= w_ar_done;
        end
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.m_araddr    = r_araddr;
    assign bus.m_arvalid   = r_arvalid;
    assign bus.m_rready    = r_rready;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_resp    = r_rsp_resp;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign bus.rsp_valid   = r_rsp_valid;
    assign busy            = r_busy;

endmodule

// File: tb/tb_axi_lite_read_requester.sv
// Bench for axi_lite_read_requester: two instances (long and short watchdog) share one
// reactive subordinate; each transaction is predicted from its handshake delays.
module tb_axi_lite_read_requester;
    import axi_lite_pkg::*;

    localparam int unsigned AW       = 32;
    localparam int unsigned DW       = 32;
    localparam int unsigned TO_LONG  = 256;
    localparam int unsigned TO_SHORT = 8;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic          sel = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic          d_cvalid = 1'b0;
    logic          d_rsp_ready = 1'b0;
    logic          d_arready, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic [1:0]    d_rresp;
    int unsigned   sub_da = 0;
    int unsigned   sub_dr = 0;
    logic [DW-1:0] sub_data = '0;
    logic [1:0]    sub_resp = '0;

    axi_lite_read_requester_if #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW)) bus_l ();
    axi_lite_read_requester_if #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW)) bus_s ();
    logic busy_l, busy_s;

    axi_lite_read_requester #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW), .TIMEOUT_CYCLES(TO_LONG)) dut_long (
        .aclk(aclk), .aresetn(aresetn), .bus(bus_l), .busy(busy_l));
    axi_lite_read_requester #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW), .TIMEOUT_CYCLES(TO_SHORT)) dut_short (
        .aclk(aclk), .aresetn(aresetn), .bus(bus_s), .busy(busy_s));

    assign bus_l.cmd_address = d_addr;
    assign bus_l.cmd_valid   = d_cvalid && !sel;
    assign bus_l.rsp_ready   = d_rsp_ready && !sel;
    assign bus_l.m_arready   = d_arready;
    assign bus_l.m_rdata     = d_rdata;
    assign bus_l.m_rresp     = d_rresp;
    assign bus_l.m_rvalid    = d_rvalid;
    assign bus_s.cmd_address = d_addr;
    assign bus_s.cmd_valid   = d_cvalid && sel;
    assign bus_s.rsp_ready   = d_rsp_ready && sel;
    assign bus_s.m_arready   = d_arready;
    assign bus_s.m_rdata     = d_rdata;
    assign bus_s.m_rresp     = d_rresp;
    assign bus_s.m_rvalid    = d_rvalid;

    logic          o_cmd_ready, o_arvalid, o_rready, o_rsp_valid, o_rsp_timeout, o_busy;
    logic [AW-1:0] o_araddr;
    logic [DW-1:0] o_rsp_data;
    logic [1:0]    o_rsp_resp;
    assign o_cmd_ready   = sel ? bus_s.cmd_ready   : bus_l.cmd_ready;
    assign o_arvalid     = sel ? bus_s.m_arvalid   : bus_l.m_arvalid;
    assign o_rready      = sel ? bus_s.m_rready    : bus_l.m_rready;
    assign o_rsp_valid   = sel ? bus_s.rsp_valid   : bus_l.rsp_valid;
    assign o_rsp_timeout = sel ? bus_s.rsp_timeout : bus_l.rsp_timeout;
    assign o_busy        = sel ? busy_s            : busy_l;
    assign o_araddr      = sel ? bus_s.m_araddr    : bus_l.m_araddr;
    assign o_rsp_data    = sel ? bus_s.rsp_data    : bus_l.rsp_data;
    assign o_rsp_resp    = sel ? bus_s.rsp_resp    : bus_l.rsp_resp;

    // Subordinate: ARREADY after sub_da cycles of ARVALID, RVALID after sub_dr cycles of RREADY
    initial begin
        int unsigned ac, rc;
        ac = 0; rc = 0;
        d_arready = 1'b0; d_rvalid = 1'b0; d_rdata = '0; d_rresp = '0;
        forever begin
            @(negedge aclk);
            if (o_arvalid) begin d_arready = (ac == sub_da); ac++; end
            else begin d_arready = 1'b0; ac = 0; end
            if (o_rready) begin d_rvalid = (rc == sub_dr); rc++; end
            else begin d_rvalid = 1'b0; rc = 0; end
            d_rdata = sub_data;
            d_rresp = sub_resp;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed=no finish expected=finish");
        $fatal(1, "bench time limit reached");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_cmd_ready"}, 64'(o_cmd_ready), 64'(0));
        check({tag, "_arvalid"},   64'(o_arvalid),   64'(0));
        check({tag, "_rready"},    64'(o_rready),    64'(0));
        check({tag, "_rsp_valid"}, 64'(o_rsp_valid), 64'(0));
        check({tag, "_timeout"},   64'(o_rsp_timeout), 64'(0));
        check({tag, "_busy"},      64'(o_busy),      64'(0));
        check({tag, "_araddr"},    64'(o_araddr),    64'(0));
        check({tag, "_rsp_data"},  64'(o_rsp_data),  64'(0));
        check({tag, "_rsp_resp"},  64'(o_rsp_resp),  64'(0));
    endtask

    task automatic issue_cmd(input logic [AW-1:0] addr);
        int unsigned n = 0;
        while (!o_cmd_ready && n < 50) begin @(negedge aclk); n++; end
        check("cmd_ready_before_cmd", 64'(o_cmd_ready), 64'(1));
        d_addr   = addr;
        d_cvalid = 1'b1;
        @(negedge aclk);
        d_cvalid = 1'b0;
        d_addr   = $urandom;
    endtask

    // Model: R handshake lands in cycle da+dr+2 after accept; it times out if beyond the limit
    task automatic run_txn(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [1:0] resp,
                           input int unsigned da, input int unsigned dr, input int unsigned hold);
        int unsigned lim, k, exp_at, cyc, seen_at, rr_cycles, rr_rises, n;
        bit tmo, prev_rr;
        logic [DW-1:0] exp_data;
        logic [1:0] exp_resp;
        lim      = sel ? TO_SHORT : TO_LONG;
        k        = da + dr + 2;
        tmo      = (lim != 0) && (k > lim);
        exp_at   = tmo ? lim + 1 : k + 1;
        exp_data = tmo ? '0 : data;
        exp_resp = tmo ? RESP_DECERR : resp;
        sub_da = da; sub_dr = dr; sub_data = data; sub_resp = resp;
        @(negedge aclk);
        issue_cmd(addr);
        cyc = 1; seen_at = 0; rr_cycles = 0; rr_rises = 0; prev_rr = 1'b0;
        while (seen_at == 0 && cyc <= 300) begin
            if (o_arvalid) check("araddr_stable", 64'(o_araddr), 64'(addr));
            if (o_rready) begin rr_cycles++; if (!prev_rr) rr_rises++; end
            prev_rr = o_rready;
            if (o_rsp_valid) seen_at = cyc;
            else begin @(negedge aclk); cyc++; end
        end
        check("rsp_latency", 64'(seen_at), 64'(exp_at));
        check("rsp_data", 64'(o_rsp_data), 64'(exp_data));
        check("rsp_resp", 64'(o_rsp_resp), 64'(exp_resp));
        check("rsp_timeout", 64'(o_rsp_timeout), 64'(tmo));
        check("cmd_ready_in_resp", 64'(o_cmd_ready), 64'(0));
        check("busy_in_resp", 64'(o_busy), 64'(1));
        check("rready_in_resp", 64'(o_rready), 64'(0));
        check("arvalid_in_resp", 64'(o_arvalid), 64'(tmo && (da >= lim)));
        if (!tmo) begin
            check("rready_cycles", 64'(rr_cycles), 64'(dr + 1));
            check("rready_pulses", 64'(rr_rises), 64'(1));
        end
        for (int unsigned h = 0; h < hold; h++) begin
            @(negedge aclk);
            check("hold_valid", 64'(o_rsp_valid), 64'(1));
            check("hold_data", 64'(o_rsp_data), 64'(exp_data));
            check("hold_resp", 64'(o_rsp_resp), 64'(exp_resp));
            check("hold_timeout", 64'(o_rsp_timeout), 64'(tmo));
            check("hold_cmd_ready", 64'(o_cmd_ready), 64'(0));
            if (!tmo) check("hold_no_new_ar", 64'(o_arvalid), 64'(0));
        end
        d_rsp_ready = 1'b1;
        @(negedge aclk);
        d_rsp_ready = 1'b0;
        check("rsp_valid_drop", 64'(o_rsp_valid), 64'(0));
        if (!tmo) begin
            check("cmd_ready_after_rsp", 64'(o_cmd_ready), 64'(1));
            check("busy_after_rsp", 64'(o_busy), 64'(0));
        end else begin
            check("cmd_ready_in_flush", 64'(o_cmd_ready), 64'(0));
            n = 0;
            while (!o_cmd_ready && n < 100) begin @(negedge aclk); n++; end
            check("flush_done", 64'(o_cmd_ready), 64'(1));
            check("flush_arvalid", 64'(o_arvalid), 64'(0));
            check("flush_rready", 64'(o_rready), 64'(0));
            check("flush_busy", 64'(o_busy), 64'(0));
        end
    endtask

    initial begin
        repeat (3) @(negedge aclk);
        sel = 1'b0; #1; check_idle_zero("rst_long");
        sel = 1'b1; #1; check_idle_zero("rst_short");
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        sel = 1'b1; #1; check("rel_cmd_ready_short", 64'(o_cmd_ready), 64'(1));
        sel = 1'b0; #1; check("rel_cmd_ready_long", 64'(o_cmd_ready), 64'(1));

        run_txn(32'h0000_0010, 32'hDEAD_BEEF, RESP_OKAY, 0, 0, 0);
        run_txn(32'h0000_0A24, 32'h1234_5678, RESP_SLVERR, 5, 4, 0);
        run_txn(32'h0000_0B00, 32'hCAFE_F00D, RESP_EXOKAY, 1, 1, 10);

        sel = 1'b1; #1;
        run_txn(32'h0000_0C40, 32'h5555_AAAA, RESP_OKAY, 12, 2, 2);
        run_txn(32'h0000_0C44, 32'h0BAD_CAFE, RESP_OKAY, 0, 6, 0);
        run_txn(32'h0000_0C48, 32'h7777_1111, RESP_SLVERR, 0, 7, 1);
        run_txn(32'h0000_0C4C, 32'h9999_2222, RESP_OKAY, 7, 0, 0);

        sel = 1'b0; #1;
        sub_da = 0; sub_dr = 40; sub_data = 32'hFFFF_0000; sub_resp = RESP_OKAY;
        @(negedge aclk);
        issue_cmd(32'h0000_0044);
        repeat (4) @(negedge aclk);
        check("mid_data_rready", 64'(o_rready), 64'(1));
        aresetn = 1'b0;
        @(negedge aclk);
        check_idle_zero("mid_rst");
        aresetn = 1'b1;
        @(negedge aclk);
        check("mid_rst_cmd_ready", 64'(o_cmd_ready), 64'(1));
        run_txn(32'h0000_0048, 32'hA5A5_5A5A, RESP_OKAY, 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            sel = 1'($urandom_range(0, 1)); #1;
            run_txn($urandom, $urandom, 2'($urandom_range(0, 3)),
                    $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
